// File: rtl/flee_rx_sink.sv
// flee_rx_sink: receive endpoint for a NoC flee egress port.
// It accepts flits over valid/ready and applies a periodic back-pressure
// window to ready. Each accepted flit is counted, recorded as the last
// flit, and folded into a rotate-XOR signature. The block flags
// completion, overflow after completion, and a no-progress watchdog.
module flee_rx_sink #(
  parameter int DW        = 32,
  parameter int CNT_W     = 32,
  parameter int BP_PERIOD = 16,
  parameter int BP_ON     = 16,
  parameter int WD_WIN    = 10000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] exp_cnt_i,
  input  logic [DW-1:0]    data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [CNT_W-1:0] flit_cnt_o,
  output logic [DW-1:0]    sig_o,
  output logic [DW-1:0]    last_data_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic             deadlock_o
);

  // Counter widths. The watchdog counter only needs to reach WD_WIN-1.
  localparam int BP_W = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
  localparam int WD_W = (WD_WIN > 2) ? $clog2(WD_WIN) : 1;

  localparam logic [BP_W-1:0]  BP_LAST = BP_W'(BP_PERIOD - 1);
  localparam logic [BP_W-1:0]  BP_ONE  = BP_W'(1);
  localparam logic [31:0]      BP_ON_U = BP_ON;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WD_WIN - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [BP_W-1:0]  bp_cnt;
  logic             bp_open;
  logic [WD_W-1:0]  wd_cnt, wd_nx, wd_inc;
  logic [CNT_W-1:0] cnt_nx, cnt_inc;
  logic [DW-1:0]    sig_nx, last_nx, sig_fold;
  logic             done_nx, ovf_nx, dl_nx;
  logic             hs;

  // Back-pressure phase counter: free-running from reset, ignores clear.
  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 bp_cnt <= '0;
    else if (bp_cnt == BP_LAST) bp_cnt <= '0;
    else                       bp_cnt <= bp_cnt + BP_ONE;
  end

  // The window is open for the first BP_ON phases of each period; BP_ON at or
  // above the period keeps it always open, zero keeps it always closed.
  assign bp_open = (32'(bp_cnt) < BP_ON_U);

  // Ready depends only on registered state, the phase counter and enable,
  // never on valid_i, so the sender can rely on it combinationally.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ready_o = 1'b0;
    case (state)
      S_RUN, S_STALL: ready_o = en_i & bp_open;
      S_DONE:         ready_o = 1'b1;
      default:        ready_o = 1'b0;
    endcase
  end

  assign hs       = valid_i & ready_o;
  assign cnt_inc  = flit_cnt_o + CNT_ONE;
  assign wd_inc   = wd_cnt + WD_ONE;
  assign sig_fold = {sig_o[DW-2:0], sig_o[DW-1]} ^ data_i;

  // Next-state and datapath update: clear overrides everything, otherwise
  // the current state decides how a handshake or an idle cycle is handled.
  always_comb begin
    state_nx = state;
    cnt_nx   = flit_cnt_o;
    sig_nx   = sig_o;
    last_nx  = last_data_o;
    wd_nx    = wd_cnt;
    done_nx  = done_o;
    ovf_nx   = ovf_o;
    dl_nx    = deadlock_o;

    if (clr_i) begin
      // A handshake in this cycle completes for the sender but is dropped.
      state_nx = S_IDLE;
      cnt_nx   = '0;
      sig_nx   = '0;
      last_nx  = '0;
      wd_nx    = '0;
      done_nx  = 1'b0;
      ovf_nx   = 1'b0;
      dl_nx    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_i) begin
            state_nx = S_RUN;
            wd_nx    = '0;
          end
        end

        S_RUN, S_STALL: begin
          if (hs) begin
            // A handshake always beats the watchdog, and leaves STALL.
            cnt_nx  = cnt_inc;
            sig_nx  = sig_fold;
            last_nx = data_i;
            wd_nx   = '0;
            if ((exp_cnt_i != '0) && (cnt_inc == exp_cnt_i)) begin
              state_nx = S_DONE;
              done_nx  = 1'b1;
            end else begin
              state_nx = S_RUN;
            end
          end else if ((state == S_RUN) && (flit_cnt_o != '0)) begin
            // Watchdog is armed only after the first flit; it counts idle
            // cycles whether or not the sink is enabled.
            wd_nx = wd_inc;
            if (wd_inc == WD_LAST) begin
              state_nx = S_STALL;
              dl_nx    = 1'b1;
            end
          end
        end

        S_DONE: begin
          // Draining: extra flits are accepted but only flag overflow.
          if (hs) ovf_nx = 1'b1;
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Datapath and sticky flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flit_cnt_o  <= '0;
      sig_o       <= '0;
      last_data_o <= '0;
      wd_cnt      <= '0;
      done_o      <= 1'b0;
      ovf_o       <= 1'b0;
      deadlock_o  <= 1'b0;
    end else begin
      flit_cnt_o  <= cnt_nx;
      sig_o       <= sig_nx;
      last_data_o <= last_nx;
      wd_cnt      <= wd_nx;
      done_o      <= done_nx;
      ovf_o       <= ovf_nx;
      deadlock_o  <= dl_nx;
    end
  end

endmodule

// File: tb/tb_flee_rx_sink.sv
// Testbench for flee_rx_sink: two instances (always-open window and a
// 4-of-16 window) share one stimulus stream; each is compared every cycle
// against a behavioural model, plus directed end-of-phase checks.
module tb_flee_rx_sink;

  localparam int DW  = 16;
  localparam int CW  = 32;
  localparam int P   = 16;
  localparam int WDW = 50;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          valid = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  logic [DW-1:0] data = '0;

  logic          rdy  [2];
  logic [CW-1:0] cnt  [2];
  logic [DW-1:0] sig  [2];
  logic [DW-1:0] last [2];
  logic          done [2];
  logic          ovf  [2];
  logic          dl   [2];

  always #5 clk = ~clk;

  flee_rx_sink #(.DW(DW), .CNT_W(CW), .BP_PERIOD(P), .BP_ON(16), .WD_WIN(WDW)) u_full (
    .clk(clk), .rstn(rstn), .en_i(en), .clr_i(clr), .exp_cnt_i(exp_cnt),
    .data_i(data), .valid_i(valid), .ready_o(rdy[0]), .flit_cnt_o(cnt[0]),
    .sig_o(sig[0]), .last_data_o(last[0]), .done_o(done[0]), .ovf_o(ovf[0]),
    .deadlock_o(dl[0])
  );

  flee_rx_sink #(.DW(DW), .CNT_W(CW), .BP_PERIOD(P), .BP_ON(4), .WD_WIN(WDW)) u_bp (
    .clk(clk), .rstn(rstn), .en_i(en), .clr_i(clr), .exp_cnt_i(exp_cnt),
    .data_i(data), .valid_i(valid), .ready_o(rdy[1]), .flit_cnt_o(cnt[1]),
    .sig_o(sig[1]), .last_data_o(last[1]), .done_o(done[1]), .ovf_o(ovf[1]),
    .deadlock_o(dl[1])
  );

  // Model: "active" = sink has been enabled since the last clear, "finished"
  // = expected count reached, "quiet" = idle edges since the last flit,
  // capped at the watchdog limit.
  typedef struct {
    bit            active;
    bit            finished;
    bit            done;
    bit            ovf;
    bit            dl;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sig;
    logic [DW-1:0] last;
    int            quiet;
  } mdl_t;

  mdl_t        m [2];
  int unsigned cyc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int bp_on(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic [DW-1:0] rot_xor(input logic [DW-1:0] s, input logic [DW-1:0] d);
    return {s[DW-2:0], s[DW-1]} ^ d;
  endfunction

  function automatic logic [DW-1:0] fold_idx(input int n);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < n; k++) s = rot_xor(s, DW'(k));
    return s;
  endfunction

  function automatic bit m_ready(input int i);
    if (!m[i].active)  return 1'b0;
    if (m[i].finished) return 1'b1;
    return en && ((cyc % P) < bp_on(i));
  endfunction

  task automatic m_reset_all();
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    cyc = 0;
  endtask

  task automatic m_step(input int i);
    bit hs;
    hs = valid && m_ready(i);
    if (clr) begin
      m[i] = '{default: 0};
    end else if (!m[i].active) begin
      if (en) m[i].active = 1'b1;
    end else if (m[i].finished) begin
      if (hs) m[i].ovf = 1'b1;
    end else if (hs) begin
      m[i].cnt   = m[i].cnt + 1;
      m[i].sig   = rot_xor(m[i].sig, data);
      m[i].last  = data;
      m[i].quiet = 0;
      if (exp_cnt != 0 && m[i].cnt == exp_cnt) begin
        m[i].finished = 1'b1;
        m[i].done     = 1'b1;
      end
    end else if (m[i].cnt != 0 && m[i].quiet < WDW - 1) begin
      m[i].quiet++;
      if (m[i].quiet == WDW - 1) m[i].dl = 1'b1;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d ready", i), rdy[i], m_ready(i));
      check($sformatf("u%0d cnt", i), cnt[i], m[i].cnt);
      check($sformatf("u%0d sig", i), sig[i], m[i].sig);
      check($sformatf("u%0d last", i), last[i], m[i].last);
      check($sformatf("u%0d done", i), done[i], m[i].done);
      check($sformatf("u%0d ovf", i), ovf[i], m[i].ovf);
      check($sformatf("u%0d deadlock", i), dl[i], m[i].dl);
    end
  endtask

  // One clock: compare mid-cycle, advance the model, return just after the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < 2; i++) m_step(i);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [CW-1:0] e);
    valid = 1'b0;
    en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_cnt = e;
    en = 1'b1;
    tick();
  endtask

  logic [DW-1:0] d5;
  int            rdy_hi;

  initial begin
    // Reset state
    m_reset_all();
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_reset_all();

    // Full-rate stream: 100 flits in 100 cycles, then overflow
    restart(32'd100);
    valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      data = DW'(k);
      tick();
    end
    check("A cnt", cnt[0], 100);
    check("A done", done[0], 1);
    check("A last", last[0], 99);
    check("A sig", sig[0], fold_idx(100));
    data = 16'hBEEF;
    repeat (2) tick();
    check("A ovf", ovf[0], 1);
    check("A cnt held", cnt[0], 100);

    // Back-pressure window: 4 of 16 cycles open
    restart(32'd0);
    valid = 1'b1;
    rdy_hi = 0;
    for (int k = 0; k < 160; k++) begin
      data = DW'($urandom);
      if (rdy[1]) rdy_hi++;
      tick();
    end
    check("B ready cycles", rdy_hi, 40);
    check("B cnt", cnt[1], 40);
    check("B cnt full", cnt[0], 160);

    // Watchdog: 3 flits then silence
    restart(32'd0);
    valid = 1'b1;
    repeat (3) begin
      data = DW'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (48) tick();
    check("C deadlock early", dl[0], 0);
    tick();
    check("C deadlock", dl[0], 1);
    valid = 1'b1;
    data = DW'($urandom);
    tick();
    valid = 1'b0;
    check("C cnt after stall", cnt[0], 4);
    check("C deadlock sticky", dl[0], 1);
    repeat (5) tick();

    // Expected count 5, send 7
    restart(32'd5);
    valid = 1'b1;
    d5 = '0;
    for (int k = 1; k <= 7; k++) begin
      data = DW'($urandom);
      if (k == 5) d5 = data;
      tick();
      if (k == 5) begin
        check("D done at 5", done[0], 1);
        check("D no ovf at 5", ovf[0], 0);
      end
      if (k == 6) check("D ovf at 6", ovf[0], 1);
    end
    valid = 1'b0;
    check("D cnt", cnt[0], 5);
    check("D last", last[0], d5);

    // Clear while a flit is offered at count 10
    restart(32'd0);
    valid = 1'b1;
    repeat (10) begin
      data = DW'($urandom);
      tick();
    end
    check("E cnt 10", cnt[0], 10);
    clr = 1'b1;
    data = 16'h5A5A;
    tick();
    clr = 1'b0;
    check("E cnt cleared", cnt[0], 0);
    check("E sig cleared", sig[0], 0);
    check("E last cleared", last[0], 0);
    check("E ready low", rdy[0], 0);
    tick();
    tick();
    check("E recount", cnt[0], 1);

    // Randomized traffic, alternating dense and sparse blocks
    for (int blk = 0; blk < 10; blk++) begin
      for (int k = 0; k < 200; k++) begin
        valid = (blk % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) == 0);
        data  = DW'($urandom);
        en    = ($urandom_range(0, 7) != 0);
        clr   = ($urandom_range(0, 149) == 0);
        if (clr) exp_cnt = CW'($urandom_range(0, 40));
        tick();
        clr = 1'b0;
      end
    end

    // Asynchronous reset mid-burst, between clock edges
    restart(32'd0);
    valid = 1'b1;
    repeat (6) begin
      data = DW'($urandom);
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    m_reset_all();
    check_outputs();
    check("G cnt async", cnt[0], 0);
    @(posedge clk);
    #1;
    en = 1'b0;
    rstn = 1'b1;
    m_reset_all();
    repeat (3) tick();
    check("G idle ready", rdy[0], 0);
    en = 1'b1;
    repeat (4) tick();
    check("G resume", cnt[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flee_rx_sink.md
Name: flee_rx_sink

Overview:
Synthesizable receive endpoint for a NoC "flee" egress port; the consuming counterpart of the stab-side packet driver. It accepts flits over a valid/ready handshake and applies a programmable periodic back-pressure pattern. It counts flits, folds each flit into a rolling signature, and flags completion, overflow and no-progress (deadlock) conditions. One instance is tied to each flee port (flee0, flee1) in system-level regression and on-board self-test.

Parameters:
DW, `DW, flit width in bits, from params.svh.
CNT_W, 32, width of the flit counter and expected-count input.
BP_PERIOD, 16, back-pressure period in cycles; must be ≥ 1.
BP_ON, 16, ready-eligible cycles per period; BP_ON ≥ BP_PERIOD means always eligible, BP_ON = 0 means never eligible.
WD_WIN, 10000, consecutive no-handshake cycles that trigger deadlock; must be ≥ 2.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
en_i  in  1  enable; gates ready_o in RUN/STALL; 0→1 leaves IDLE.
clr_i  in  1  synchronous clear; highest priority after reset.
exp_cnt_i  in  CNT_W  expected flit count, 0 = unbounded; held stable outside IDLE.
data_i  in  DW  flit from flee port.
valid_i  in  1  flit valid.
ready_o  out  1  sink ready.
flit_cnt_o  out  CNT_W  counted flits.
sig_o  out  DW  rolling signature.
last_data_o  out  DW  most recently counted flit.
done_o  out  1  flit_cnt_o == exp_cnt_i (exp ≠ 0), sticky.
ovf_o  out  1  flit accepted after DONE, sticky.
deadlock_o  out  1  watchdog expired, sticky.

Behaviour:
- Reset (rstn=0, async): state=IDLE; ready_o=0; flit_cnt_o=0; sig_o=0; last_data_o=0; done_o=0; ovf_o=0; deadlock_o=0; bp_cnt=0; wd_cnt=0.
- Handshake: hs = valid_i & ready_o, sampled at posedge. ready_o is a function of registered state, bp_cnt and en_i only, never of valid_i. data_i is captured on hs with zero added latency: outputs update at the same edge.
- bp_cnt: free-running after reset, increments every cycle in all states and wraps BP_PERIOD-1→0. bp_open = (bp_cnt < BP_ON). clr_i does not reset bp_cnt.
- States:
  - IDLE: ready_o=0. Goes to RUN at the edge where en_i=1. wd_cnt is cleared on entry to RUN.
  - RUN: ready_o = en_i & bp_open.
    - On hs: flit_cnt+=1; sig = {sig[DW-2:0],sig[DW-1]} ^ data_i; last_data = data_i; wd_cnt=0.
    - If exp≠0 and the post-increment count == exp: go to DONE and set done_o at the same edge.
    - With no hs and flit_cnt>0: wd_cnt+=1. wd_cnt == WD_WIN-1 with no hs → STALL, deadlock_o=1.
    - wd_cnt holds at 0 while flit_cnt==0, so the watchdog is not armed before the first flit. It counts regardless of en_i.
  - STALL: ready_o = en_i & bp_open. hs updates counters and signature exactly as in RUN, then returns to RUN (or DONE if the count reaches exp). deadlock_o stays 1.
  - DONE: ready_o=1 (drain). hs sets ovf_o=1. flit_cnt, sig and last_data are not updated.
- Widths: flit_cnt wraps modulo 2^CNT_W with no saturation. The signature rotate is by 1 bit.
- clr_i=1 at an edge: state→IDLE; flit_cnt, sig, last_data, wd_cnt, done_o, ovf_o and deadlock_o all cleared. A simultaneous hs is discarded; because ready_o is combinational, the sender still sees the handshake complete. The re-entry to RUN happens at a later edge with en_i=1.
- en_i falling in RUN: ready_o drops in the same cycle; state is retained.
- Simultaneous hs at wd_cnt == WD_WIN-1: hs wins, with no STALL.
- Reset mid-transfer: all state is lost and the upstream flit remains pending (valid held).

Test Plan:
- BP_ON=BP_PERIOD=16, exp=100, valid_i=1 with data = index 0..99 → 100 hs in 100 consecutive cycles; flit_cnt_o=100; done_o=1; last_data_o=99; sig_o equals the model's rotate-XOR over 0..99.
- BP_PERIOD=16, BP_ON=4, valid_i always 1, exp=0 → ready_o high exactly 4 of every 16 cycles, aligned to bp_cnt 0..3; after 160 cycles flit_cnt_o=40.
- WD_WIN=50, send 3 flits then valid_i=0 → deadlock_o rises 49 cycles after the 3rd hs; a 4th flit gives flit_cnt_o=4, state back to RUN, deadlock_o still 1.
- exp=5, send 7 flits → done_o after the 5th; ovf_o=1 after the 6th; flit_cnt_o=5; last_data_o=flit #5.
- clr_i pulsed while valid_i=1 at cnt=10 → that flit is dropped, all outputs return to 0 and ready_o=0 the next cycle; with en_i=1, RUN resumes and counts from 0.
- rstn asserted asynchronously mid-burst, between edges → all outputs are 0 immediately; after release, IDLE until en_i=1.
